alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arb_pkg.sv | 17 +
 rtl/alu4_core.sv | 25 ++
 rtl/alu_arbiter.sv | 97 +++++++++
 tb/tb_alu_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared opcode constants, FSM state type and default datapath width for the ALU arbiter.
package alu_arb_pkg;

  localparam int W_DEF = 4;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu4_core.sv
// Combinational W-bit ALU: AND / OR / SUB (a-b) / ADD, modulo 2^W, no flags.
// Zero latency; no flow control.
module alu4_core
  import alu_arb_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [1:0]   func,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] c
);

  always_comb begin
    c = '0;
    case (func)
      OP_AND: c = a & b;
      OP_OR:  c = a | b;
      OP_SUB: c = a - b;
      OP_ADD: c = a + b;
      default: c = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one ALU; round-robin when ALU_ARB_RR_EN is defined, else requester 0 priority.
// Request latched in IDLE, done pulses in RESP (one op per 3 cycles); requesters hold req until done.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int ID_W = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic [1:0]      func0,
  input  logic [W-1:0]    a0,
  input  logic [W-1:0]    b0,
  input  logic            req1,
  input  logic [1:0]      func1,
  input  logic [W-1:0]    a1,
  input  logic [W-1:0]    b1,
  output logic            done0,
  output logic            done1,
  output logic [W-1:0]    result,
  output logic            busy,
  output logic [ID_W-1:0] owner
);

  state_t         state, state_nxt;
  logic [1:0]     op_func;
  logic [W-1:0]   op_a, op_b, alu_c;
  logic           any_req, grant1, latch;

  assign any_req = req0 | req1;
  assign latch   = (state == IDLE) && any_req;

`ifdef ALU_ARB_RR_EN
  // fav1 set means requester 1 wins a tie (requester 0 was served last).
  logic fav1;
  assign grant1 = req1 & (~req0 | fav1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        fav1 <= 1'b0;
    else if (latch) fav1 <= ~grant1;
  end
`else
  assign grant1 = req1 & ~req0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done0     = 1'b0;
    done1     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (any_req) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        state_nxt = IDLE;
        done0     = (owner == '0);
        done1     = (owner == ID_W'(1));
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_func <= '0;
      op_a    <= '0;
      op_b    <= '0;
      owner   <= '0;
      result  <= '0;
    end else begin
      if (latch) begin
        op_func <= grant1 ? func1 : func0;
        op_a    <= grant1 ? a1 : a0;
        op_b    <= grant1 ? b1 : b0;
        owner   <= grant1 ? ID_W'(1) : '0;
      end
      if (state == EXEC) result <= alu_c;
    end
  end

  alu4_core #(.W(W)) u_core (
    .func (op_func),
    .a    (op_a),
    .b    (op_b),
    .c    (alu_c)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomised self-checking bench for alu_arbiter (honours ALU_ARB_RR_EN).
module tb_alu_arbiter;

  localparam int W = 4;
`ifdef ALU_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [1:0]   func0 = '0, func1 = '0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         done0, done1, busy;
  logic [W-1:0] result;
  logic [0:0]   owner;

  int n_checks = 0, n_fail = 0;
  int both_hi = 0, bad_done = 0, done_seen = 0;

  alu_arbiter #(.W(W), .ID_W(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .func0(func0), .a0(a0), .b0(b0),
    .req1(req1), .func1(func1), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .result(result), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done0 && done1) both_hi++;
    if ((done0 || done1) && !busy) bad_done++;
    if (done0 || done1) done_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] wide;
    case (f)
      2'b00:   wide = {1'b0, a & b};
      2'b01:   wide = {1'b0, a | b};
      2'b10:   wide = {1'b0, a} + {1'b0, ~b} + 1;
      default: wide = {1'b0, a} + {1'b0, b};
    endcase
    return wide[W-1:0];
  endfunction

  // Waits (bounded) for a done pulse and checks edge count, which requester, result and owner.
  task automatic wait_done(input string tag, input int exp_edges, input logic exp_d1, input logic [W-1:0] exp_res);
    int  edges = 0;
    bit  seen  = 1'b0;
    while (!seen && edges < 10) begin
      @(posedge clk); #1;
      edges++;
      seen = done0 | done1;
    end
    check({tag, "_lat"},   32'(edges),  32'(exp_edges));
    check({tag, "_done0"}, 32'(done0),  32'(!exp_d1));
    check({tag, "_done1"}, 32'(done1),  32'(exp_d1));
    check({tag, "_res"},   32'(result), 32'(exp_res));
    check({tag, "_owner"}, 32'(owner),  32'(exp_d1));
  endtask

  task automatic idle_step();
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bit           r0, r1, win1, fav1;
    logic [W-1:0] exp_res;
    int           seen_before;

    #1 rst = 1'b1;
    #2;
    check("rst_busy",   32'(busy),   0);
    check("rst_done0",  32'(done0),  0);
    check("rst_done1",  32'(done1),  0);
    check("rst_result", 32'(result), 0);
    check("rst_owner",  32'(owner),  0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single ADD from requester 0: 7+5 = 0xC.
    req0 = 1'b1; func0 = 2'b11; a0 = 4'd7; b0 = 4'd5;
    wait_done("add0", 2, 1'b0, 4'hC);
    idle_step();

    // Single SUB from requester 1 wraps: 2-3 = 0xF.
    req1 = 1'b1; func1 = 2'b10; a1 = 4'd2; b1 = 4'd3;
    @(posedge clk); #1;
    check("sub1_busy",  32'(busy),  1);
    check("sub1_owner", 32'(owner), 1);
    check("sub1_early", 32'(done1), 0);
    wait_done("sub1", 1, 1'b1, 4'hF);
    idle_step();
    check("idle_busy",       32'(busy),  0);
    check("idle_owner_last", 32'(owner), 1);

    // Both held continuously: RR alternates 0/1, fixed priority always serves 0.
    req0 = 1'b1; func0 = 2'b00; a0 = 4'hC; b0 = 4'hA;
    req1 = 1'b1; func1 = 2'b01; a1 = 4'hC; b1 = 4'hA;
    for (int k = 0; k < 4; k++) begin
      win1 = RR_EN && (k % 2 == 1);
      wait_done($sformatf("both%0d", k), (k == 0) ? 2 : 3, win1, win1 ? 4'hE : 4'h8);
    end
    idle_step();

    // Operands changed after the latch edge must not affect the in-flight op.
    req0 = 1'b1; func0 = 2'b11; a0 = 4'd1; b0 = 4'd1;
    @(posedge clk); #1;
    a0 = 4'd9; b0 = 4'hF; func0 = 2'b00;
    wait_done("stable", 1, 1'b0, 4'd2);
    idle_step();

    // Reset during EXEC discards the operation.
    req1 = 1'b1; func1 = 2'b11; a1 = 4'd3; b1 = 4'd4;
    @(posedge clk); #1;
    check("rstm_owner_pre", 32'(owner), 1);
    req1 = 1'b0;
    rst  = 1'b1;
    #1;
    check("rstm_busy",   32'(busy),   0);
    check("rstm_result", 32'(result), 0);
    check("rstm_owner",  32'(owner),  0);
    check("rstm_done1",  32'(done1),  0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_before = done_seen;
    repeat (5) @(posedge clk);
    #1;
    check("rstm_no_done", 32'(done_seen - seen_before), 0);
    check("rstm_idle",    32'(busy), 0);

    // After reset the tie goes to requester 0 in either build.
    req0 = 1'b1; func0 = 2'b10; a0 = 4'd0; b0 = 4'd1;
    req1 = 1'b1; func1 = 2'b00; a1 = 4'hF; b1 = 4'hF;
    wait_done("post_rst_tie", 2, 1'b0, 4'hF);
    idle_step();

    // Random ops against the reference model; requester 0 was served last.
    fav1 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      req0 = r0; func0 = 2'($urandom_range(0, 3)); a0 = W'($urandom_range(0, 15)); b0 = W'($urandom_range(0, 15));
      req1 = r1; func1 = 2'($urandom_range(0, 3)); a1 = W'($urandom_range(0, 15)); b1 = W'($urandom_range(0, 15));
      win1    = r1 && (!r0 || (RR_EN && fav1));
      exp_res = win1 ? ref_alu(func1, a1, b1) : ref_alu(func0, a0, b0);
      fav1    = !win1;
      @(posedge clk); #1;
      a0 = ~a0; a1 = ~a1; func0 = ~func0; func1 = ~func1;
      wait_done("rnd", 1, win1, exp_res);
      idle_step();
    end

    check("done_exclusive", 32'(both_hi),  0);
    check("done_only_busy", 32'(bad_done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
